// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS multiplier.
//
// Holds the width constants, the fixed pipeline depth, the per-stage record
// used for the operand stage, and the reset-flop macro used for every
// register in the multiplier.
//
// Contents:
//   DATA_W       operand width (the product is 2*DATA_W wide)
//   REG_ADDR_W   register-file address width
//   N_STAGES     pipeline depth P0,P1,P2,P3,W (fixed, not a parameter)
//   mult_stage_t valid / signedness / destination / data record

// Asynchronous active-low reset flop: q_ takes rv_ while rst_n_ is low,
// otherwise it loads d_ on every rising clock edge.
`ifndef MIPS_DFF_AR
`define MIPS_DFF_AR(q_, d_, rv_, clk_, rst_n_) \
    always_ff @(posedge clk_ or negedge rst_n_) begin \
        if (!rst_n_) q_ <= rv_; \
        else         q_ <= d_; \
    end
`endif

package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int N_STAGES   = 5;
    localparam int CNT_W      = 3;

    // One pipeline slot: the valid bit alone qualifies the other fields.
    typedef struct packed {
        logic                    valid;
        logic                    is_signed;
        logic [REG_ADDR_W-1:0]   dest;
        logic [2*DATA_W-1:0]     data;
    } mult_stage_t;

endpackage

// File: rtl/mips_mult_pipe_if.sv
// Bus between decode / write-back and the pipelined multiplier.
//
// master modport (decode side): drives the issue request, operands and
// destination; observes write-back, per-stage valid/dest and the in-flight
// count.
// slave modport (multiplier): the reverse.
//
// Signals:
//   mult_start_D, stall, flush, signed_D   issue control
//   src_a_D, src_b_D, dest_addr_D           operands and destination
//   wb_valid_W, wb_addr_W, wb_lo_W, wb_hi_W write-back
//   stage_valid[3:0], stage_dest[3:0]       P0..P3 hazard view
//   inflight_cnt                            ops live in P0..W
interface mips_mult_pipe_if #(
    parameter int DATA_W = mips_pkg::DATA_W
);
    import mips_pkg::*;

    logic                            mult_start_D;
    logic                            stall;
    logic                            flush;
    logic                            signed_D;
    logic [DATA_W-1:0]               src_a_D;
    logic [DATA_W-1:0]               src_b_D;
    logic [REG_ADDR_W-1:0]           dest_addr_D;

    logic                            wb_valid_W;
    logic [REG_ADDR_W-1:0]           wb_addr_W;
    logic [DATA_W-1:0]               wb_lo_W;
    logic [DATA_W-1:0]               wb_hi_W;
    logic [3:0]                      stage_valid;
    logic [3:0][REG_ADDR_W-1:0]      stage_dest;
    logic [CNT_W-1:0]                inflight_cnt;

    modport master (
        output mult_start_D, stall, flush, signed_D,
               src_a_D, src_b_D, dest_addr_D,
        input  wb_valid_W, wb_addr_W, wb_lo_W, wb_hi_W,
               stage_valid, stage_dest, inflight_cnt
    );

    modport slave (
        input  mult_start_D, stall, flush, signed_D,
               src_a_D, src_b_D, dest_addr_D,
        output wb_valid_W, wb_addr_W, wb_lo_W, wb_hi_W,
               stage_valid, stage_dest, inflight_cnt
    );

endinterface

// File: rtl/mips_mult_pp16.sv
// Partial-product cell: multiplies two IN_W-bit halves, each independently
// treated as signed or unsigned, and returns the product modulo 2^OUT_W.
//
// Ports:
//   a_i, b_i                 IN_W-bit operand halves
//   a_signed_i, b_signed_i   1 = sign-extend that half, 0 = zero-extend
//   p_o                      OUT_W-bit product (two's complement, truncated)
module mips_mult_pp16 #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  a_i,
    input  logic [IN_W-1:0]  b_i,
    input  logic             a_signed_i,
    input  logic             b_signed_i,
    output logic [OUT_W-1:0] p_o
);

    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;

    assign a_ext = {{(OUT_W-IN_W){a_signed_i & a_i[IN_W-1]}}, a_i};
    assign b_ext = {{(OUT_W-IN_W){b_signed_i & b_i[IN_W-1]}}, b_i};

    // Once both operands are extended to OUT_W, a plain truncated multiply
    // gives the exact product modulo 2^OUT_W for any signedness mix.
    assign p_o = a_ext * b_ext;

endmodule

// File: rtl/mips_mult_pipe.sv
// Five-stage pipelined DATA_W x DATA_W multiplier for the MIPS core.
//
//   P0  registers operands, sign flag and destination
//   P1  four half-width partial products (LL, LH, HL, HH)
//   P2  sums the two cross terms
//   P3  forms the final 2*DATA_W product
//   W   registers the result and raises wb_valid_W for one cycle
//
// The pipe never stalls: stall only blocks issue. flush kills every in-flight
// op and any issue in the same cycle.
//
// Ports:
//   clk   single clock
//   rst   asynchronous, active-low reset
//   bus   mips_mult_pipe_if slave modport (issue, write-back, hazard view)
module mips_mult_pipe #(
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    mips_mult_pipe_if.slave bus
);
    import mips_pkg::*;

    localparam int HW     = DATA_W / 2;
    localparam int PW     = 2 * DATA_W;
    localparam int CW     = DATA_W + HW;
    // Stages after P0 are tracked in vld_q/dst_q: index 0=P1, 1=P2, 2=P3, 3=W.
    localparam int N_PIPE = N_STAGES - 1;
    localparam int W_IDX  = N_PIPE - 1;

    logic                               issue;

    mult_stage_t                        p0_d, p0_q;
    logic [N_PIPE-1:0]                  vld_d, vld_q;
    logic [N_PIPE-1:0][REG_ADDR_W-1:0]  dst_d, dst_q;
    logic [N_PIPE-1:0]                  up_vld;
    logic [N_PIPE-1:0][REG_ADDR_W-1:0]  up_dst;

    logic [PW-1:0]                      p1_base_d, p1_base_q;
    logic [CW-1:0]                      p1_lh_d, p1_lh_q;
    logic [CW-1:0]                      p1_hl_d, p1_hl_q;
    logic [PW-1:0]                      p2_base_d, p2_base_q;
    logic [CW-1:0]                      p2_mid_d, p2_mid_q;
    logic [PW-1:0]                      p3_prod_d, p3_prod_q;
    logic [PW-1:0]                      w_prod_d, w_prod_q;
    logic [CNT_W-1:0]                   cnt_d, cnt_q;

    logic [HW-1:0]                      a_lo, a_hi, b_lo, b_hi;
    logic [DATA_W-1:0]                  pp_ll, pp_hh;
    logic [CW-1:0]                      pp_lh, pp_hl;

    assign issue = bus.mult_start_D & ~bus.stall & ~bus.flush;

    assign {a_hi, a_lo} = p0_q.data[PW-1:DATA_W];
    assign {b_hi, b_lo} = p0_q.data[DATA_W-1:0];

    // The low halves are always unsigned; only the high halves carry the sign.
    // LL and HH only matter modulo 2^DATA_W because they land in disjoint
    // halves of the product; the cross terms only matter modulo 2^CW because
    // they are shifted left by HW.
    mips_mult_pp16 #(.IN_W(HW), .OUT_W(DATA_W)) u_pp_ll (
        .a_i        (a_lo),
        .b_i        (b_lo),
        .a_signed_i (1'b0),
        .b_signed_i (1'b0),
        .p_o        (pp_ll)
    );

    mips_mult_pp16 #(.IN_W(HW), .OUT_W(CW)) u_pp_lh (
        .a_i        (a_lo),
        .b_i        (b_hi),
        .a_signed_i (1'b0),
        .b_signed_i (p0_q.is_signed),
        .p_o        (pp_lh)
    );

    mips_mult_pp16 #(.IN_W(HW), .OUT_W(CW)) u_pp_hl (
        .a_i        (a_hi),
        .b_i        (b_lo),
        .a_signed_i (p0_q.is_signed),
        .b_signed_i (1'b0),
        .p_o        (pp_hl)
    );

    mips_mult_pp16 #(.IN_W(HW), .OUT_W(DATA_W)) u_pp_hh (
        .a_i        (a_hi),
        .b_i        (b_hi),
        .a_signed_i (p0_q.is_signed),
        .b_signed_i (p0_q.is_signed),
        .p_o        (pp_hh)
    );

    // Valid/destination chain: each stage takes what the stage before held.
    // flush clears every valid bit; destinations only move with a valid op
    // so an empty stage keeps its last address.
    assign up_vld = {vld_q[N_PIPE-2:0], p0_q.valid};
    assign up_dst = {dst_q[N_PIPE-2:0], p0_q.dest};

    always_comb begin
        p0_d       = p0_q;
        p0_d.valid = issue;
        if (issue) begin
            p0_d.is_signed = bus.signed_D;
            p0_d.dest      = bus.dest_addr_D;
            p0_d.data      = {bus.src_a_D, bus.src_b_D};
        end

        vld_d = up_vld & {N_PIPE{~bus.flush}};
        dst_d = dst_q;
        for (int k = 0; k < N_PIPE; k++) begin
            if (up_vld[k]) begin
                dst_d[k] = up_dst[k];
            end
        end
    end

    // Datapath registers load only when the feeding stage holds a valid op.
    // LL and HH occupy disjoint halves, so P1 stores them concatenated as one
    // partial sum; P3 then needs a single add of the shifted cross term.
    always_comb begin
        p1_base_d = p1_base_q;
        p1_lh_d   = p1_lh_q;
        p1_hl_d   = p1_hl_q;
        p2_base_d = p2_base_q;
        p2_mid_d  = p2_mid_q;
        p3_prod_d = p3_prod_q;
        w_prod_d  = w_prod_q;

        if (p0_q.valid) begin
            p1_base_d = {pp_hh, pp_ll};
            p1_lh_d   = pp_lh;
            p1_hl_d   = pp_hl;
        end
        if (vld_q[0]) begin
            p2_base_d = p1_base_q;
            p2_mid_d  = p1_lh_q + p1_hl_q;
        end
        if (vld_q[1]) begin
            p3_prod_d = p2_base_q + {p2_mid_q, {HW{1'b0}}};
        end
        if (vld_q[2]) begin
            w_prod_d = p3_prod_q;
        end
    end

    // In-flight counter: +1 on issue, -1 as W retires; flush empties the pipe.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(issue) - CNT_W'(vld_q[W_IDX]);
        end
    end

    `MIPS_DFF_AR(p0_q,      p0_d,      '0, clk, rst)
    `MIPS_DFF_AR(vld_q,     vld_d,     '0, clk, rst)
    `MIPS_DFF_AR(dst_q,     dst_d,     '0, clk, rst)
    `MIPS_DFF_AR(p1_base_q, p1_base_d, '0, clk, rst)
    `MIPS_DFF_AR(p1_lh_q,   p1_lh_d,   '0, clk, rst)
    `MIPS_DFF_AR(p1_hl_q,   p1_hl_d,   '0, clk, rst)
    `MIPS_DFF_AR(p2_base_q, p2_base_d, '0, clk, rst)
    `MIPS_DFF_AR(p2_mid_q,  p2_mid_d,  '0, clk, rst)
    `MIPS_DFF_AR(p3_prod_q, p3_prod_d, '0, clk, rst)
    `MIPS_DFF_AR(w_prod_q,  w_prod_d,  '0, clk, rst)
    `MIPS_DFF_AR(cnt_q,     cnt_d,     '0, clk, rst)

    assign bus.wb_valid_W   = vld_q[W_IDX];
    assign bus.wb_addr_W    = dst_q[W_IDX];
    assign bus.wb_lo_W      = w_prod_q[DATA_W-1:0];
    assign bus.wb_hi_W      = w_prod_q[PW-1:DATA_W];
    assign bus.stage_valid  = {vld_q[2:0], p0_q.valid};
    assign bus.stage_dest   = {dst_q[2], dst_q[1], dst_q[0], p0_q.dest};
    assign bus.inflight_cnt = cnt_q;

endmodule

// File: tb/tb_mips_mult_pipe.sv
// Self-checking bench for mips_mult_pipe.
//
// Every op accepted by the bench is recorded as "retires at edge N with this
// address and this product"; the expected pipeline view (write-back, stage
// valid/dest, in-flight count) is derived from the age of each pending op.
module tb_mips_mult_pipe;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mips_mult_pipe_if #(.DATA_W(DATA_W)) bus();

    mips_mult_pipe #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int                    retireEdge;
        logic [REG_ADDR_W-1:0] addr;
        logic [63:0]           prod;
    } expOp_t;

    expOp_t pending[$];
    int     edgeNo       = 0;
    int     totalChecks  = 0;
    int     badChecks    = 0;
    int     peakInflight = 0;

    // Reference product straight from the arithmetic definition.
    function automatic logic [63:0] refProduct(logic [31:0] a, logic [31:0] b, logic sgn);
        logic signed [63:0] sr;
        logic        [63:0] ur;
        if (sgn) begin
            sr = 64'($signed(a)) * 64'($signed(b));
            return sr;
        end
        ur = {32'b0, a} * {32'b0, b};
        return ur;
    endfunction

    task automatic checkOutput(string tag, logic [63:0] got, logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edgeNo);
        end
    endtask

    // Compare every output against the view implied by the pending ops.
    task automatic checkCycle();
        logic                       expWb    = 1'b0;
        logic [REG_ADDR_W-1:0]      expAddr  = '0;
        logic [63:0]                expProd  = '0;
        logic [3:0]                 expStage = '0;
        logic [3:0][REG_ADDR_W-1:0] expDest  = '0;
        int                         live     = 0;
        foreach (pending[i]) begin
            int age;
            age = pending[i].retireEdge - edgeNo;
            if (age >= 0 && age <= 4) begin
                live++;
                if (age == 0) begin
                    expWb   = 1'b1;
                    expAddr = pending[i].addr;
                    expProd = pending[i].prod;
                end else begin
                    expStage[4-age] = 1'b1;
                    expDest[4-age]  = pending[i].addr;
                end
            end
        end
        checkOutput("wb_valid", 64'(bus.wb_valid_W), 64'(expWb));
        if (expWb) begin
            checkOutput("wb_addr", 64'(bus.wb_addr_W), 64'(expAddr));
            checkOutput("wb_lo",   64'(bus.wb_lo_W),   64'(expProd[31:0]));
            checkOutput("wb_hi",   64'(bus.wb_hi_W),   64'(expProd[63:32]));
        end
        checkOutput("stage_valid", 64'(bus.stage_valid), 64'(expStage));
        for (int k = 0; k < 4; k++) begin
            if (expStage[k]) begin
                checkOutput("stage_dest", 64'(bus.stage_dest[k]), 64'(expDest[k]));
            end
        end
        checkOutput("inflight_cnt", 64'(bus.inflight_cnt), 64'(live));
        if (int'(bus.inflight_cnt) > peakInflight) peakInflight = int'(bus.inflight_cnt);
    endtask

    // Drive one cycle of inputs, update the model at the edge, then check.
    task automatic applyStimulus(logic start, logic stl, logic fl, logic sgn,
                                 logic [31:0] a, logic [31:0] b,
                                 logic [REG_ADDR_W-1:0] dest);
        expOp_t e;
        bus.mult_start_D = start;
        bus.stall        = stl;
        bus.flush        = fl;
        bus.signed_D     = sgn;
        bus.src_a_D      = a;
        bus.src_b_D      = b;
        bus.dest_addr_D  = dest;
        @(posedge clk);
        edgeNo++;
        if (fl) begin
            pending.delete();
        end else begin
            while (pending.size() > 0 && pending[0].retireEdge < edgeNo) void'(pending.pop_front());
            if (start && !stl) begin
                e.retireEdge = edgeNo + 4;
                e.addr       = dest;
                e.prod       = refProduct(a, b, sgn);
                pending.push_back(e);
            end
        end
        #1;
        checkCycle();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic checkAllZero(string tag);
        checkOutput({tag, "_wb_valid"},    64'(bus.wb_valid_W),   64'd0);
        checkOutput({tag, "_wb_addr"},     64'(bus.wb_addr_W),    64'd0);
        checkOutput({tag, "_wb_lo"},       64'(bus.wb_lo_W),      64'd0);
        checkOutput({tag, "_wb_hi"},       64'(bus.wb_hi_W),      64'd0);
        checkOutput({tag, "_stage_valid"}, 64'(bus.stage_valid),  64'd0);
        checkOutput({tag, "_stage_dest"},  64'(bus.stage_dest),   64'd0);
        checkOutput({tag, "_inflight"},    64'(bus.inflight_cnt), 64'd0);
    endtask

    // Assert reset between edges, verify it acts at once, hold one cycle.
    task automatic pulseReset();
        bus.mult_start_D = 1'b0;
        bus.stall        = 1'b0;
        bus.flush        = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAllZero("reset_mid");
        pending.delete();
        @(posedge clk);
        edgeNo++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        bus.mult_start_D = 1'b0;
        bus.stall        = 1'b0;
        bus.flush        = 1'b0;
        bus.signed_D     = 1'b0;
        bus.src_a_D      = '0;
        bus.src_b_D      = '0;
        bus.dest_addr_D  = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkAllZero("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] directed: 7 x 6 unsigned");
        while (edgeNo < 9) idle(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 5'd5);
        idle(6);

        $display("[TB] directed: -3 x 4 signed and unsigned");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4, 5'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd4, 5'd2);
        idle(6);

        $display("[TB] directed: five back-to-back ops");
        peakInflight = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd11);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd12);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd14);
        idle(6);
        checkOutput("inflight_peak", 64'(peakInflight), 64'd5);

        $display("[TB] directed: stall blocks issue");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd9, 32'd9, 5'd7);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 5'd7);
        idle(6);

        $display("[TB] directed: flush with concurrent issue");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 5'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd2, 5'd4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd100, 32'd200, 5'd6);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd11, 32'd13, 5'd8);
        idle(6);

        $display("[TB] directed: reset with ops in P1 and P3");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd21, 32'd2, 5'd20);
        idle(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, 5'd21);
        idle(1);
        pulseReset();
        idle(6);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3, 5'd22);
        idle(5);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 24) == 0,
                          1'($urandom_range(0, 1)),
                          pickOperand(), pickOperand(),
                          REG_ADDR_W'($urandom_range(0, 31)));
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/mips_mult_pipe.md
MIPS_MULT_PIPE -- requirements
Module: mips_mult_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width.
REQ-002 SHALL have parameter N_STAGES, fixed 5 (P0,P1,P2,P3,W); SHALL be a package constant, not overridable.
REQ-003 SHALL have port clk, input, 1, single clock for all state.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port mult_start_D, input, 1, multiply issue request from decode.
REQ-006 SHALL have port stall, input, 1, issue block from the stall generator.
REQ-007 SHALL have port flush, input, 1, kill all in-flight multiplies.
REQ-008 SHALL have port signed_D, input, 1, 1 = signed operands, 0 = unsigned.
REQ-009 SHALL have ports src_a_D and src_b_D, input, DATA_W each, operands.
REQ-010 SHALL have port dest_addr_D, input, REG_ADDR_W, destination register.
REQ-011 SHALL have port wb_valid_W, output, 1, write-back request.
REQ-012 SHALL have port wb_addr_W, output, REG_ADDR_W, write-back register.
REQ-013 SHALL have ports wb_lo_W and wb_hi_W, output, DATA_W each, product low/high halves.
REQ-014 SHALL have port stage_valid, output, 4, valid bits for P0..P3 (bit0 = P0).
REQ-015 SHALL have port stage_dest, output, 4xREG_ADDR_W, dest address per P0..P3, for hazard checks.
REQ-016 SHALL have port inflight_cnt, output, 3, number of valid ops in P0..W (0-5).

Function
REQ-017 Issue SHALL occur when mult_start_D=1, stall=0 and flush=0 at a rising edge; the op then enters P0.
REQ-018 The pipeline SHALL always advance; stall blocks issue only, never freezes in-flight ops.
REQ-019 An op issued in cycle N SHALL produce wb_valid_W=1 for exactly one cycle, cycle N+5.
REQ-020 P0 SHALL register operands, sign flag and dest; P1 SHALL form four 16x16 partial products (sign-extended when signed); P2 SHALL sum the cross terms; P3 SHALL produce the final 2*DATA_W product; W SHALL register the result.
REQ-021 The product SHALL be exact modulo 2^(2*DATA_W): signed for signed_D=1, unsigned otherwise.
REQ-022 Back-to-back issues on every cycle SHALL be accepted, with one result per cycle.
REQ-023 flush=1 SHALL clear stage_valid and wb_valid_W at the next edge; an issue in the same cycle SHALL be dropped (flush wins).
REQ-024 Invalid stages SHALL hold data/address unchanged; the valid bits alone qualify them.
REQ-025 wb_addr_W, wb_lo_W and wb_hi_W SHALL be meaningful only while wb_valid_W=1.
REQ-026 inflight_cnt SHALL be a registered up/down counter: +1 on issue, -1 when W retires, net 0 when both occur; it SHALL reset to 0 on flush.
REQ-027 inflight_cnt SHALL equal popcount(stage_valid)+wb_valid_W at all times.

Reset
REQ-028 Asserting rst low SHALL immediately clear all valid bits, wb_valid_W and inflight_cnt to 0, and clear data/address registers to 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight ops; no write-back SHALL follow deassertion.
REQ-030 The first issue SHALL be accepted at the first rising edge after rst deassertion.

Structure
REQ-031 REG_ADDR_W, DATA_W, N_STAGES and a mult_stage_t struct (valid, signed, dest, data) SHALL reside in mips_pkg.
REQ-032 Flops SHALL be built with the team reset-flop macro.
REQ-033 One sub-module, mips_mult_pp16 (a signed/unsigned 16x16 partial-product cell), SHALL be instantiated four times in P1.

Verification
REQ-034 Issue 7 x 6, unsigned, dest 5 in cycle 10 -> wb_valid_W=1 in cycle 15 only, wb_addr_W=5, wb_lo_W=42, wb_hi_W=0.
REQ-035 Issue -3 x 4, signed -> wb_lo_W=0xFFFFFFF4, wb_hi_W=0xFFFFFFFF; the same operands unsigned -> wb_hi_W=0x00000003, wb_lo_W=0xFFFFFFF4.
REQ-036 Issue 5 consecutive ops (0xFFFFFFFF x 0xFFFFFFFF unsigned, then others) -> 5 consecutive results; the first has hi=0xFFFFFFFE, lo=0x00000001; inflight_cnt peaks at 5.
REQ-037 mult_start_D=1 with stall=1 for 3 cycles -> no issue and stage_valid=0; then stall=0 -> one issue, result 5 cycles later.
REQ-038 Issue 3 ops, then flush with a concurrent issue -> no wb_valid_W afterwards, and inflight_cnt=0 the next cycle.
REQ-039 rst low for 1 cycle while 2 ops are in P1/P3 -> all outputs 0 immediately and no write-back afterwards.
